// File: rtl/usb_tx_if.sv
// Request/buffer/line bundle between a USB transmitter and the logic that feeds it.
// The master side supplies packet requests and TX buffer state; the slave side is the transmitter.
interface usb_tx_if;
  logic [2:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       get_tx_packet_data;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_transfer_active;
  logic       tx_error;

  modport master (
    output tx_packet, tx_packet_data, buffer_occupancy,
    input  get_tx_packet_data, dplus_out, dminus_out, tx_transfer_active, tx_error
  );

  modport slave (
    input  tx_packet, tx_packet_data, buffer_occupancy,
    output get_tx_packet_data, dplus_out, dminus_out, tx_transfer_active, tx_error
  );
endinterface

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, NRZI, bit stuffing and EOP.
// Define USB_TX_ERR_EN to enable the tx_error pulse for ignored requests and truncated payloads.
module usb_tx #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64
) (
  input logic   clk,
  input logic   n_rst,
  usb_tx_if.slave bus
);

  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned ByteW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {StIdle, StSync, StPid, StData, StCrc, StEop} state_e;

  state_e            state_q, state_d, nxt_state;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d, nxt_idx;
  logic              stuff_q, stuff_d;
  logic [2:0]        ones_q, ones_d;
  logic              level_q, level_d;
  logic              se0_q, se0_d;
  logic [3:0]        pid_q, pid_d, req_pid;
  logic [7:0]        byte_q, byte_d;
  logic [15:0]       crc_q, crc_d;
  logic [ByteW-1:0]  bytes_q, bytes_d;
  logic              more_q, more_d;

  logic       accept, boundary, is_data_pid, byte_check, room, pop, tx_bit, send;
  logic [7:0] pid_byte;

  assign accept      = (bus.tx_packet != 3'd0) && (bus.tx_packet <= 3'd5);
  assign boundary    = (state_q != StIdle) && (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign is_data_pid = (pid_q == 4'h3) || (pid_q == 4'hB);
  assign pid_byte    = {~pid_q, pid_q};
  // First cycle of the period carrying bit 7 of the PID or of a payload byte.
  assign byte_check  = ((state_q == StPid) || (state_q == StData)) && (idx_q == 4'd7) &&
                       !stuff_q && (cnt_q == '0);
  assign room        = bytes_q < ByteW'(MAX_PAYLOAD);
  assign pop         = byte_check && is_data_pid && (bus.buffer_occupancy != 7'd0) && room;

  always_comb begin
    unique case (bus.tx_packet)
      3'd1:    req_pid = 4'h3;
      3'd2:    req_pid = 4'hB;
      3'd3:    req_pid = 4'h2;
      3'd4:    req_pid = 4'hA;
      default: req_pid = 4'hE;
    endcase
  end

  // Position of the next real (non-stuffed) bit after the current one.
  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q + 4'd1;
    case (state_q)
      StSync: if (idx_q == 4'd7) begin nxt_state = StPid; nxt_idx = '0; end
      StPid: begin
        if (idx_q == 4'd7) begin
          nxt_idx   = '0;
          nxt_state = more_q ? StData : (is_data_pid ? StCrc : StEop);
        end
      end
      StData: if (idx_q == 4'd7) begin nxt_state = more_q ? StData : StCrc; nxt_idx = '0; end
      StCrc:  if (idx_q == 4'd15) begin nxt_state = StEop; nxt_idx = '0; end
      StEop:  if (idx_q == 4'd2) begin nxt_state = StIdle; nxt_idx = '0; end
      default: begin nxt_state = StIdle; nxt_idx = '0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stuff_d = stuff_q;
    ones_d  = ones_q;
    level_d = level_q;
    se0_d   = se0_q;
    pid_d   = pid_q;
    byte_d  = byte_q;
    crc_d   = crc_q;
    bytes_d = bytes_q;
    more_d  = more_q;
    tx_bit  = 1'b1;
    send    = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
      if (accept) begin
        state_d = StSync;
        idx_d   = '0;
        stuff_d = 1'b0;
        ones_d  = '0;
        level_d = 1'b0;  // first SYNC bit is a 0, so J turns into K
        se0_d   = 1'b0;
        bytes_d = '0;
        more_d  = 1'b0;
        pid_d   = req_pid;
      end
    end else begin
      cnt_d = boundary ? '0 : cnt_q + CntW'(1);
      if (byte_check) begin
        more_d = pop;
        if (pop) begin
          byte_d  = bus.tx_packet_data;
          bytes_d = bytes_q + ByteW'(1);
        end
      end
      if (boundary) begin
        if ((ones_q == 3'd6) && (state_q != StEop)) begin
          stuff_d = 1'b1;
          ones_d  = '0;
          level_d = ~level_q;
        end else begin
          stuff_d = 1'b0;
          state_d = nxt_state;
          idx_d   = nxt_idx;
          case (nxt_state)
            StSync: begin send = 1'b1; tx_bit = (nxt_idx == 4'd7); end
            StPid: begin
              send   = 1'b1;
              tx_bit = pid_byte[nxt_idx[2:0]];
              if (nxt_idx == 4'd0) crc_d = 16'hFFFF;
            end
            StData: begin
              send   = 1'b1;
              tx_bit = byte_q[nxt_idx[2:0]];
              // LSB-first CRC16: 0xA001 is polynomial 0x8005 bit-reversed.
              crc_d  = {1'b0, crc_q[15:1]} ^ ((tx_bit ^ crc_q[0]) ? 16'hA001 : 16'h0000);
            end
            StCrc: begin
              send   = 1'b1;
              tx_bit = ~crc_q[0];
              crc_d  = {1'b0, crc_q[15:1]};
            end
            StEop: begin
              se0_d   = (nxt_idx != 4'd2);
              level_d = 1'b1;
              ones_d  = '0;
            end
            default: begin
              se0_d   = 1'b0;
              level_d = 1'b1;
              ones_d  = '0;
            end
          endcase
          if (send) begin
            level_d = tx_bit ? level_q : ~level_q;
            ones_d  = tx_bit ? ones_q + 3'd1 : 3'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      stuff_q <= 1'b0;
      ones_q  <= '0;
      level_q <= 1'b1;
      se0_q   <= 1'b0;
      pid_q   <= '0;
      byte_q  <= '0;
      crc_q   <= '0;
      bytes_q <= '0;
      more_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stuff_q <= stuff_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      se0_q   <= se0_d;
      pid_q   <= pid_d;
      byte_q  <= byte_d;
      crc_q   <= crc_d;
      bytes_q <= bytes_d;
      more_q  <= more_d;
    end
  end

  assign bus.dplus_out          = ~se0_q & level_q;
  assign bus.dminus_out         = ~se0_q & ~level_q;
  assign bus.tx_transfer_active = (state_q != StIdle);
  assign bus.get_tx_packet_data = pop;

`ifdef USB_TX_ERR_EN
  logic err_q, err_d;

  assign err_d = ((state_q != StIdle) && (bus.tx_packet != 3'd0)) ||
                 ((state_q == StIdle) && (bus.tx_packet >= 3'd6)) ||
                 (byte_check && is_data_pid && (bus.buffer_occupancy != 7'd0) && !room);

  always_ff @(posedge clk) begin
    if (n_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.tx_error = err_q;
`else
  assign bus.tx_error = 1'b0;
`endif

endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
- USB full-speed packet transmitter; the transmit-side counterpart of the USB receive path in the USB-AHB module.
- Takes a packet-type request plus payload bytes from the TX data buffer.
- Serialises SYNC, PID, payload and CRC16 with NRZI encoding and bit stuffing, then drives EOP onto dplus_out/dminus_out.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period (>=4)
MAX_PAYLOAD, 64, maximum data bytes per DATA packet; further bytes not consumed

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous reset, active-high (1 = reset on next clk edge)
tx_packet  input  3  request strobe, sampled only in IDLE: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 ignored
tx_packet_data  input  8  head byte of TX buffer, valid combinationally
buffer_occupancy  input  7  bytes currently in TX buffer
get_tx_packet_data  output  1  one-cycle pop pulse to TX buffer
dplus_out  output  1  D+ line
dminus_out  output  1  D- line
tx_transfer_active  output  1  high while a packet is on the lines
tx_error  output  1  one-cycle error pulse (see Optional Feature)

Behaviour:
- Reset: state IDLE; dplus_out=1, dminus_out=0 (J); get_tx_packet_data=0; tx_transfer_active=0; tx_error=0; all counters and CRC cleared. Reset mid-packet aborts the packet: lines show J and state is IDLE on the cycle after reset is sampled. No partial EOP is sent.
- States: IDLE -> SYNC -> PID -> (DATA -> CRC) or direct -> EOP -> IDLE.
- Accept: in IDLE, tx_packet in 1..5 is latched. tx_transfer_active rises the next cycle. The first SYNC bit is driven on that same cycle.
- Bit timer: counts 0..CLKS_PER_BIT-1. Lines change only when the count is 0; each bit holds for exactly CLKS_PER_BIT cycles.
- Bit order: all fields are sent LSB first.
  - SYNC = 0x80, i.e. seven 0s then a 1.
  - PID byte = {~pid[3:0], pid[3:0]}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- NRZI: a 0 toggles J/K; a 1 holds the previous level. The level before SYNC is J.
- Bit stuffing:
  - A ones counter counts consecutive 1s, starting at SYNC. The SYNC final 1 counts.
  - After six consecutive 1s, one stuffed 0 (a toggle) is inserted and the counter clears.
  - A stuffed bit occupies a full bit period. The payload bit pointer and CRC do not advance during it.
  - Stuffing continues across byte and field boundaries, including the last CRC bit (a stuff bit may precede EOP). It never applies in EOP.
- DATA flow:
  - At the last bit period of the PID or of a payload byte, if buffer_occupancy>0 and bytes_sent<MAX_PAYLOAD: pulse get_tx_packet_data for one cycle and latch tx_packet_data in that cycle.
  - Otherwise go to CRC. Zero-length packets are legal.
- CRC16: polynomial 0x8005, initialised to 0xFFFF at PID start, updated over payload bits only (not stuff bits). It is transmitted complemented, 16 bits LSB first.
- ACK/NAK/STALL: PID then EOP. The buffer is never popped.
- EOP: SE0 (both lines 0) for 2 bit periods, then J for 1 bit period. IDLE is entered after that J period; tx_transfer_active falls in the same cycle.
- A new tx_packet while not in IDLE is ignored.
- tx_packet=6/7 in IDLE is ignored.

Optional Feature:
- Macro: USB_TX_ERR_EN.
- Defined: tx_error pulses one cycle when any of these occurs:
  - tx_packet is nonzero while not in IDLE.
  - tx_packet=6/7 in IDLE.
  - A DATA packet hits MAX_PAYLOAD while buffer_occupancy is still >0.
  - Transmission behaviour is otherwise unchanged.
- Undefined: tx_error is tied 0 and no detection logic is synthesised. Requests are still ignored and payloads still truncated identically.

Test Plan:
- Reset, then hold idle: lines J (1,0), tx_transfer_active=0, no pops, over 100 cycles.
- ACK request:
  - 19 bit periods = 152 cycles active.
  - Line sequence per bit: K J K J K J K K | J J K J J K K K | SE0 SE0 J.
  - Then IDLE.
- DATA1 with buffer_occupancy=0:
  - Zero pops; CRC field sent as 0x0000 (16 toggles).
  - 35 bit periods = 280 cycles active.
- DATA0 with one byte 0xFF in the buffer:
  - Exactly one pop, in the last period of the PID.
  - A stuffed toggle is inserted after the 4th payload bit.
  - CRC matches the bench CRC16 model.
- DATA0 with buffer_occupancy=70 held constant:
  - Exactly 64 pops, then CRC and EOP.
  - With USB_TX_ERR_EN: one tx_error pulse; without it tx_error stays 0.
- Reset asserted mid-payload:
  - Next cycle lines J, tx_transfer_active=0, no further pops.
  - A following ACK request transmits correctly.
